// File: rtl/bp_update_ctrl_pkg.sv
// Shared definitions for the branch-predictor pattern table: default sizes,
// 2-bit counter encodings, controller states and the saturating counter update.
package bp_update_ctrl_pkg;

  localparam int unsigned IDX_W_DEF = 10;
  localparam int unsigned DEPTH_DEF = 4;

  typedef enum logic [1:0] {
    SNT = 2'd0,
    WNT = 2'd1,
    WT  = 2'd2,
    ST  = 2'd3
  } ctr_e;

  localparam logic [1:0] INIT_CTR_DEF = 2'(WNT);

  typedef enum logic {
    SWEEP = 1'b0,
    RUN   = 1'b1
  } state_e;

  // Saturating 2-bit counter step toward the resolved direction
  function automatic logic [1:0] sat_update(input logic [1:0] c, input logic taken);
    if (taken) return (c == 2'(ST))  ? c : c + 2'd1;
    else       return (c == 2'(SNT)) ? c : c - 2'd1;
  endfunction

endpackage

// File: rtl/bp_hist_fifo.sv
// In-order queue of in-flight predictions; head entry is read combinationally.
module bp_hist_fifo #(
  parameter int unsigned W     = 21,
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         i_push,
  input  logic [W-1:0]                 i_data,
  input  logic                         i_pop,
  input  logic                         i_flush,
  output logic [W-1:0]                 o_head,
  output logic [$clog2(DEPTH+1)-1:0]   o_count
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [W-1:0]     r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign w_do_push = i_push && (r_count < CNT_W'(DEPTH));
  assign w_do_pop  = i_pop && (r_count != '0);

  always_ff @(posedge clk) begin
    if (w_do_push && !i_flush) r_mem[r_wr_ptr] <= i_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (!rstn || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= PTR_W'(r_wr_ptr + 1'b1);
      if (w_do_pop)  r_rd_ptr <= PTR_W'(r_rd_ptr + 1'b1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= CNT_W'(r_count + 1'b1);
        2'b01:   r_count <= CNT_W'(r_count - 1'b1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/bp_update_ctrl.sv
// Pattern-table update controller: init sweep, in-flight prediction queue,
// saturating counter write-back with read-after-write bypass, and ghr repair.
module bp_update_ctrl
  import bp_update_ctrl_pkg::*;
#(
  parameter int unsigned IDX_W    = IDX_W_DEF,
  parameter int unsigned DEPTH    = DEPTH_DEF,
  parameter logic [1:0]  INIT_CTR = INIT_CTR_DEF
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             i_pred_valid,
  input  logic [IDX_W-1:0] i_pred_idx,
  input  logic             i_pred_taken,
  output logic             o_pred_ready,
  input  logic             i_res_valid,
  input  logic             i_res_taken,
  input  logic             i_clear,
  output logic [IDX_W-1:0] o_tbl_rd_idx,
  input  logic [1:0]       i_tbl_rd_data,
  output logic             o_tbl_we,
  output logic [IDX_W-1:0] o_tbl_wr_idx,
  output logic [1:0]       o_tbl_wr_data,
  output logic [IDX_W-1:0] o_ghr,
  output logic             o_mispredict
);

  localparam int unsigned ENT_W = 2 * IDX_W + 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  state_e           r_state;
  logic [IDX_W-1:0] r_sweep_ctr;
  logic [IDX_W-1:0] r_ghr;
  logic             r_tbl_we;
  logic [IDX_W-1:0] r_tbl_wr_idx;
  logic [1:0]       r_tbl_wr_data;
  logic             r_mispredict;

  logic [ENT_W-1:0] w_head;
  logic [CNT_W-1:0] w_count;
  logic [IDX_W-1:0] w_head_idx;
  logic             w_head_taken;
  logic [IDX_W-1:0] w_head_ghr;
  logic             w_run;
  logic             w_resolve;
  logic             w_mispred;
  logic             w_pred_ready;
  logic             w_push;
  logic [1:0]       w_ctr_cur;

  // Entry layout: {idx, predicted direction, ghr before the prediction}
  assign w_head_idx   = w_head[ENT_W-1 -: IDX_W];
  assign w_head_taken = w_head[IDX_W];
  assign w_head_ghr   = w_head[IDX_W-1:0];

  assign w_run        = (r_state == RUN);
  assign w_resolve    = w_run && i_res_valid && (w_count != '0) && !i_clear;
  assign w_mispred    = w_resolve && (i_res_taken != w_head_taken);
  assign w_pred_ready = w_run && (w_count < CNT_W'(DEPTH)) && !w_mispred && !i_clear;
  assign w_push       = i_pred_valid && w_pred_ready;

  // The RAM has not yet absorbed a write registered last cycle
  assign w_ctr_cur = (r_tbl_we && (r_tbl_wr_idx == w_head_idx)) ? r_tbl_wr_data : i_tbl_rd_data;

  bp_hist_fifo #(
    .W     (ENT_W),
    .DEPTH (DEPTH)
  ) u_hist_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .i_push  (w_push),
    .i_data  ({i_pred_idx, i_pred_taken, r_ghr}),
    .i_pop   (w_resolve),
    .i_flush (i_clear || w_mispred),
    .o_head  (w_head),
    .o_count (w_count)
  );

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state       <= SWEEP;
      r_sweep_ctr   <= '0;
      r_ghr         <= '0;
      r_tbl_we      <= 1'b0;
      r_tbl_wr_idx  <= '0;
      r_tbl_wr_data <= '0;
      r_mispredict  <= 1'b0;
    end else begin
      r_tbl_we     <= 1'b0;
      r_mispredict <= 1'b0;
      if (i_clear) begin
        r_state     <= SWEEP;
        r_sweep_ctr <= '0;
        r_ghr       <= '0;
      end else begin
        case (r_state)
          SWEEP: begin
            r_tbl_we      <= 1'b1;
            r_tbl_wr_idx  <= r_sweep_ctr;
            r_tbl_wr_data <= INIT_CTR;
            r_sweep_ctr   <= IDX_W'(r_sweep_ctr + 1'b1);
            if (r_sweep_ctr == '1) r_state <= RUN;
          end
          RUN: begin
            if (w_resolve) begin
              r_tbl_we      <= 1'b1;
              r_tbl_wr_idx  <= w_head_idx;
              r_tbl_wr_data <= sat_update(w_ctr_cur, i_res_taken);
            end
            // Mispredict repairs history from the head; younger pushes are wrong-path
            if (w_mispred) begin
              r_mispredict <= 1'b1;
              r_ghr        <= {w_head_ghr[IDX_W-2:0], i_res_taken};
            end else if (w_push) begin
              r_ghr <= {r_ghr[IDX_W-2:0], i_pred_taken};
            end
          end
        endcase
      end
    end
  end

  assign o_pred_ready  = w_pred_ready;
  assign o_tbl_rd_idx  = w_head_idx;
  assign o_tbl_we      = r_tbl_we;
  assign o_tbl_wr_idx  = r_tbl_wr_idx;
  assign o_tbl_wr_data = r_tbl_wr_data;
  assign o_ghr         = r_ghr;
  assign o_mispredict  = r_mispredict;

endmodule

// File: tb/tb_bp_update_ctrl.sv
// Scoreboard bench for bp_update_ctrl with a 16-entry table and a 4-deep queue.
module tb_bp_update_ctrl;

  localparam int unsigned IDX_W = 4;
  localparam int unsigned DEPTH = 4;

  typedef struct {
    logic [IDX_W-1:0] idx;
    logic [1:0]       data;
    logic             misp;
  } wr_t;

  logic             clk;
  logic             rstn;
  logic             pred_valid;
  logic [IDX_W-1:0] pred_idx;
  logic             pred_taken;
  logic             pred_ready;
  logic             res_valid;
  logic             res_taken;
  logic             clear;
  logic [IDX_W-1:0] tbl_rd_idx;
  logic [1:0]       tbl_rd_data;
  logic             tbl_we;
  logic [IDX_W-1:0] tbl_wr_idx;
  logic [1:0]       tbl_wr_data;
  logic [IDX_W-1:0] ghr;
  logic             mispredict;

  logic [1:0]       tbl [2**IDX_W];
  logic             pl_en;
  logic [IDX_W-1:0] pl_idx;
  logic [1:0]       pl_val;

  wr_t exp_q [$];
  wr_t mon_e;
  int  n_checks;
  int  n_pass;

  bp_update_ctrl #(
    .IDX_W    (IDX_W),
    .DEPTH    (DEPTH),
    .INIT_CTR (2'b01)
  ) dut (
    .clk           (clk),
    .rstn          (rstn),
    .i_pred_valid  (pred_valid),
    .i_pred_idx    (pred_idx),
    .i_pred_taken  (pred_taken),
    .o_pred_ready  (pred_ready),
    .i_res_valid   (res_valid),
    .i_res_taken   (res_taken),
    .i_clear       (clear),
    .o_tbl_rd_idx  (tbl_rd_idx),
    .i_tbl_rd_data (tbl_rd_data),
    .o_tbl_we      (tbl_we),
    .o_tbl_wr_idx  (tbl_wr_idx),
    .o_tbl_wr_data (tbl_wr_data),
    .o_ghr         (ghr),
    .o_mispredict  (mispredict)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Table RAM: a registered write lands one edge after it appears on the port
  always @(posedge clk) begin
    if (tbl_we === 1'b1) tbl[tbl_wr_idx] <= tbl_wr_data;
    if (pl_en) tbl[pl_idx] <= pl_val;
  end
  assign tbl_rd_data = tbl[tbl_rd_idx];

  // Scoreboard: every table write must match the oldest expected write
  always @(negedge clk) begin
    if (tbl_we === 1'b1) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_write: got idx=%0d data=%0d misp=%b, none expected",
                 tbl_wr_idx, tbl_wr_data, mispredict);
      end else begin
        mon_e = exp_q.pop_front();
        if ({tbl_wr_idx, tbl_wr_data, mispredict} !== {mon_e.idx, mon_e.data, mon_e.misp})
          $display("FAIL table_write: got idx=%0d data=%0d misp=%b, expected idx=%0d data=%0d misp=%b",
                   tbl_wr_idx, tbl_wr_data, mispredict, mon_e.idx, mon_e.data, mon_e.misp);
        else
          n_pass++;
      end
    end else if (mispredict === 1'b1) begin
      n_checks++;
      $display("FAIL stray_mispredict: got mispredict=1 with no table write, expected 0");
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_wr(input logic [IDX_W-1:0] idx, input logic [1:0] data, input logic misp);
    wr_t e;
    e.idx  = idx;
    e.data = data;
    e.misp = misp;
    exp_q.push_back(e);
  endtask

  task automatic expect_sweep();
    for (int i = 0; i < 2**IDX_W; i++) expect_wr(IDX_W'(i), 2'b01, 1'b0);
  endtask

  task automatic idle_inputs();
    pred_valid = 1'b0;
    pred_idx   = '0;
    pred_taken = 1'b0;
    res_valid  = 1'b0;
    res_taken  = 1'b0;
    clear      = 1'b0;
    pl_en      = 1'b0;
  endtask

  task automatic do_reset();
    n_checks++;
    if (exp_q.size() != 0)
      $display("FAIL leftover_writes: got %0d outstanding, expected 0", exp_q.size());
    else
      n_pass++;
    exp_q.delete();
    rstn = 1'b0;
    idle_inputs();
    tick();
    tick();
    rstn = 1'b1;
    expect_sweep();
    repeat (2**IDX_W) tick();
  endtask

  task automatic preload(input logic [IDX_W-1:0] idx, input logic [1:0] val);
    pl_en  = 1'b1;
    pl_idx = idx;
    pl_val = val;
    tick();
    pl_en  = 1'b0;
  endtask

  task automatic push(input logic [IDX_W-1:0] idx, input logic taken);
    pred_valid = 1'b1;
    pred_idx   = idx;
    pred_taken = taken;
    tick();
    pred_valid = 1'b0;
  endtask

  task automatic resolve(input logic taken, input logic [IDX_W-1:0] idx,
                         input logic [1:0] data, input logic misp);
    expect_wr(idx, data, misp);
    res_valid = 1'b1;
    res_taken = taken;
    tick();
    res_valid = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    idle_inputs();
    tick();
    tick();
    n_checks++;
    if ({tbl_we, tbl_wr_idx, tbl_wr_data} !== '0)
      $display("FAIL reset_wr_port: got we=%b idx=%0d data=%0d, expected all 0", tbl_we, tbl_wr_idx, tbl_wr_data);
    else n_pass++;
    n_checks++;
    if ({ghr, mispredict, pred_ready} !== '0)
      $display("FAIL reset_status: got ghr=%0h misp=%b ready=%b, expected all 0", ghr, mispredict, pred_ready);
    else n_pass++;
    // Resolutions and predictions offered during the sweep must be ignored
    res_valid  = 1'b1;
    res_taken  = 1'b1;
    pred_valid = 1'b1;
    rstn = 1'b1;
    expect_sweep();
    repeat (2**IDX_W - 1) tick();
    n_checks++;
    if (pred_ready !== 1'b0) $display("FAIL ready_in_sweep: got %b expected 0", pred_ready);
    else n_pass++;
    tick();
    n_checks++;
    if (pred_ready !== 1'b1) $display("FAIL ready_after_sweep: got %b expected 1", pred_ready);
    else n_pass++;
    idle_inputs();
    tick();
    n_checks++;
    if (ghr !== 4'b0000) $display("FAIL ghr_after_sweep: got %b expected 0000", ghr);
    else n_pass++;
  endtask

  task automatic test_saturate();
    do_reset();
    preload(4'd5, 2'd2);
    push(4'd5, 1'b1);
    n_checks++;
    if (ghr !== 4'b0001) $display("FAIL sat_ghr1: got %b expected 0001", ghr);
    else n_pass++;
    resolve(1'b1, 4'd5, 2'd3, 1'b0);
    tick();
    push(4'd5, 1'b1);
    resolve(1'b1, 4'd5, 2'd3, 1'b0);
    n_checks++;
    if (ghr !== 4'b0011) $display("FAIL sat_ghr2: got %b expected 0011", ghr);
    else n_pass++;
    tick();
  endtask

  task automatic test_mispredict();
    do_reset();
    preload(4'd3, 2'd2);
    push(4'd3, 1'b1);
    push(4'd9, 1'b1);
    n_checks++;
    if (ghr !== 4'b0011) $display("FAIL misp_ghr_pre: got %b expected 0011", ghr);
    else n_pass++;
    // Wrong resolution of A with a new prediction offered in the same cycle
    pred_valid = 1'b1;
    pred_idx   = 4'd6;
    pred_taken = 1'b1;
    expect_wr(4'd3, 2'd1, 1'b1);
    res_valid  = 1'b1;
    res_taken  = 1'b0;
    #1;
    n_checks++;
    if (pred_ready !== 1'b0) $display("FAIL misp_ready_forced: got %b expected 0", pred_ready);
    else n_pass++;
    @(posedge clk);
    #1;
    idle_inputs();
    n_checks++;
    if ({mispredict, ghr} !== {1'b1, 4'b0000})
      $display("FAIL misp_pulse_ghr: got misp=%b ghr=%b expected misp=1 ghr=0000", mispredict, ghr);
    else n_pass++;
    res_valid = 1'b1;
    res_taken = 1'b1;
    tick();
    res_valid = 1'b0;
    n_checks++;
    if ({mispredict, pred_ready, ghr} !== {1'b0, 1'b1, 4'b0000})
      $display("FAIL misp_empty_after: got misp=%b ready=%b ghr=%b expected 0 1 0000", mispredict, pred_ready, ghr);
    else n_pass++;
    tick();
    preload(4'd4, 2'd0);
    push(4'd2, 1'b1);
    push(4'd4, 1'b1);
    resolve(1'b1, 4'd2, 2'd2, 1'b0);
    n_checks++;
    if (ghr !== 4'b0011) $display("FAIL ghr_correct_res: got %b expected 0011", ghr);
    else n_pass++;
    resolve(1'b0, 4'd4, 2'd0, 1'b1);
    n_checks++;
    if ({mispredict, ghr} !== {1'b1, 4'b0010})
      $display("FAIL ghr_restore: got misp=%b ghr=%b expected misp=1 ghr=0010", mispredict, ghr);
    else n_pass++;
    tick();
  endtask

  task automatic test_back_to_back();
    do_reset();
    preload(4'd7, 2'd1);
    push(4'd7, 1'b1);
    push(4'd7, 1'b1);
    resolve(1'b1, 4'd7, 2'd2, 1'b0);
    resolve(1'b1, 4'd7, 2'd3, 1'b0);
    n_checks++;
    if (ghr !== 4'b0011) $display("FAIL b2b_ghr: got %b expected 0011", ghr);
    else n_pass++;
    tick();
    tick();
  endtask

  task automatic test_full();
    do_reset();
    push(4'd0, 1'b1);
    push(4'd1, 1'b1);
    push(4'd2, 1'b1);
    push(4'd3, 1'b1);
    n_checks++;
    if ({pred_ready, ghr} !== {1'b0, 4'b1111})
      $display("FAIL full_ready: got ready=%b ghr=%b expected 0 1111", pred_ready, ghr);
    else n_pass++;
    pred_valid = 1'b1;
    pred_idx   = 4'd8;
    pred_taken = 1'b0;
    expect_wr(4'd0, 2'd2, 1'b0);
    res_valid  = 1'b1;
    res_taken  = 1'b1;
    #1;
    n_checks++;
    if (pred_ready !== 1'b0) $display("FAIL full_pop_push_ready: got %b expected 0", pred_ready);
    else n_pass++;
    @(posedge clk);
    #1;
    res_valid = 1'b0;
    n_checks++;
    if ({pred_ready, ghr} !== {1'b1, 4'b1111})
      $display("FAIL full_next_ready: got ready=%b ghr=%b expected 1 1111", pred_ready, ghr);
    else n_pass++;
    tick();
    pred_valid = 1'b0;
    n_checks++;
    if (ghr !== 4'b1110) $display("FAIL full_push_ghr: got %b expected 1110", ghr);
    else n_pass++;
    resolve(1'b1, 4'd1, 2'd2, 1'b0);
    resolve(1'b1, 4'd2, 2'd2, 1'b0);
    resolve(1'b1, 4'd3, 2'd2, 1'b0);
    resolve(1'b0, 4'd8, 2'd0, 1'b0);
    res_valid = 1'b1;
    tick();
    res_valid = 1'b0;
    n_checks++;
    if (ghr !== 4'b1110) $display("FAIL full_drain_ghr: got %b expected 1110", ghr);
    else n_pass++;
    tick();
  endtask

  task automatic test_clear();
    do_reset();
    push(4'd1, 1'b1);
    push(4'd2, 1'b1);
    push(4'd3, 1'b0);
    n_checks++;
    if (ghr !== 4'b0110) $display("FAIL clear_ghr_pre: got %b expected 0110", ghr);
    else n_pass++;
    clear     = 1'b1;
    res_valid = 1'b1;
    res_taken = 1'b0;
    tick();
    clear     = 1'b0;
    res_valid = 1'b0;
    n_checks++;
    if ({tbl_we, mispredict, ghr, pred_ready} !== {1'b0, 1'b0, 4'b0000, 1'b0})
      $display("FAIL clear_state: got we=%b misp=%b ghr=%b ready=%b expected 0 0 0000 0",
               tbl_we, mispredict, ghr, pred_ready);
    else n_pass++;
    for (int i = 0; i < 5; i++) expect_wr(IDX_W'(i), 2'b01, 1'b0);
    repeat (5) tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    n_checks++;
    if (tbl_we !== 1'b0) $display("FAIL clear_in_sweep_we: got %b expected 0", tbl_we);
    else n_pass++;
    expect_sweep();
    repeat (2**IDX_W - 1) tick();
    n_checks++;
    if (pred_ready !== 1'b0) $display("FAIL clear_ready_in_sweep: got %b expected 0", pred_ready);
    else n_pass++;
    tick();
    n_checks++;
    if (pred_ready !== 1'b1) $display("FAIL clear_ready_after: got %b expected 1", pred_ready);
    else n_pass++;
    res_valid = 1'b1;
    tick();
    res_valid = 1'b0;
    tick();
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    pl_idx   = '0;
    pl_val   = '0;
    rstn     = 1'b0;
    idle_inputs();
    test_reset();
    test_saturate();
    test_mispredict();
    test_back_to_back();
    test_full();
    test_clear();
    tick();
    n_checks++;
    if (exp_q.size() != 0) $display("FAIL pending_writes: got %0d outstanding, expected 0", exp_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/bp_update_ctrl.md
# bp_update_ctrl

Update controller for the 2-bit-counter pattern table of the fetch-stage branch predictor. It holds a small in-order queue of in-flight predictions and retires them as branches resolve in execute. Each resolution produces one saturating counter write per cycle, and mispredicts restore the speculative global history. The block also owns the table-initialisation sweep after reset or `clear`. It sits between fetch (prediction side), execute (resolution side) and the table RAM write port.

## Interface
- IDX_W, 10, table index width and global-history width
- DEPTH, 4, in-flight prediction queue entries (power of 2)
- INIT_CTR, 2'b01, counter value written by the sweep (weakly not-taken)
- clk  in  1  clock
- rstn  in  1  reset, synchronous, active-low
- pred_valid  in  1  fetch issued a prediction this cycle
- pred_idx  in  IDX_W  table index used for that prediction
- pred_taken  in  1  predicted direction
- pred_ready  out  1  prediction accepted when pred_valid & pred_ready
- res_valid  in  1  execute resolves the oldest in-flight branch
- res_taken  in  1  actual direction
- clear  in  1  one-cycle pulse: flush queue, zero history, re-sweep table
- tbl_rd_idx  out  IDX_W  combinational read address (= head entry idx)
- tbl_rd_data  in  2  combinational read data for tbl_rd_idx
- tbl_we / tbl_wr_idx / tbl_wr_data  out  1 / IDX_W / 2  registered table write port
- ghr  out  IDX_W  speculative global history to fetch
- mispredict  out  1  registered one-cycle pulse on a wrong prediction

## Operation
- FSM states: SWEEP, RUN. Reset → SWEEP, sweep_ctr=0.
- SWEEP:
  - Each cycle, register a write of INIT_CTR to sweep_ctr, then increment it.
  - After the write to index 2^IDX_W−1, go to RUN.
  - pred_ready=0; res_valid is ignored.
- RUN, accepting a prediction:
  - Push {pred_idx, pred_taken, ghr_before}.
  - ghr ← {ghr[IDX_W−2:0], pred_taken}.
  - pred_ready = (count < DEPTH). A pop in the same cycle does not free the slot.
- RUN, res_valid with the queue non-empty:
  - Pop the head.
  - New counter c' = taken ? min(c+1,3) : max(c−1,0), where c = tbl_rd_data.
  - Register the write {head.idx, c'}.
- RUN, res_valid with the queue empty: ignored; no write, no pulse.
- Mispredict (res_taken ≠ head.pred_taken):
  - Clear the whole queue; all younger entries are wrong-path.
  - ghr ← {head.ghr_before[IDX_W−2:0], res_taken}.
  - Pulse mispredict.
  - A prediction offered in the same cycle is dropped, and pred_ready is forced to 0 in that cycle.
- Correct resolution: ghr is not touched by the resolution. A simultaneous push still shifts ghr.
- Read-after-write bypass: if a registered write is pending to tbl_wr_idx == tbl_rd_idx, use tbl_wr_data as c instead of tbl_rd_data. Back-to-back resolutions to the same index therefore count correctly.
- clear:
  - Overrides everything in the same cycle: queue emptied, ghr←0, no resolution write.
  - Enter SWEEP from index 0.
  - clear during SWEEP restarts the sweep at 0.

## Timing
- Reset values: pred_ready=0, tbl_we=0, tbl_wr_idx=0, tbl_wr_data=0, ghr=0, mispredict=0, queue empty.
- First sweep write is visible on the first edge after rstn is sampled high. Sweep lasts 2^IDX_W cycles. pred_ready rises the cycle after the last sweep write.
- Resolution → table write: 1 cycle (tbl_we high exactly one cycle).
- Resolution → mispredict pulse: 1 cycle. ghr restore is visible on the same edge.
- Throughput: 1 push + 1 pop per cycle.
- Reset mid-operation: behaves as a fresh reset. Any pending write is cancelled.

## Structure
- Shared include bp_defs.vh:
  - IDX_W default
  - counter constants SNT=0, WNT=1, WT=2, ST=3
  - INIT_CTR
  - queue entry field widths/offsets
- Used by this block and the predictor.
- Sub-module bp_hist_fifo: DEPTH-entry synchronous FIFO with push, pop, flush and count. Entry width IDX_W+1+IDX_W; head data is combinational.
- FSM, ghr, saturating arithmetic and bypass live in the top.

## Test plan
- Reset, IDX_W=4: 16 consecutive writes of 2'b01 to idx 0..15, then pred_ready=1 on cycle 17.
- Push idx=5 taken, resolve taken with table=2: write {5,3}, no mispredict. Repeat: write {5,3} (saturation).
- ghr=0, push A (taken) and B (taken), ghr=2'b11. Resolve A not-taken: mispredict pulse, ghr=0, queue empty, write {A.idx, c−1}.
- Two pushes to idx=7, table=1, resolve both taken on consecutive cycles: writes {7,2} then {7,3} via bypass.
- Fill DEPTH=4: pred_ready=0. Pop + push in the same cycle: push not accepted. Next cycle: accepted.
- clear with 3 entries in flight plus a simultaneous res_valid: no resolution write, ghr=0, sweep restarts at idx 0.
